// File: rtl/cordic_req_arbiter.sv
// Round-robin arbiter sharing one cordic_sin_cos engine among NREQ requesters.
// Sequences the engine start/done handshake, rejects bad angles and aborts on engine timeout.
module cordic_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_angle,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_sine,
    output logic [15:0]          rsp_cosine,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 eng_start,
    output logic [15:0]          eng_angle,
    input  logic [15:0]          eng_sine,
    input  logic [15:0]          eng_cosine,
    input  logic                 eng_done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitClr,
        StWaitDone,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     angle_q, angle_d;
    logic [15:0]     sine_q, sine_d;
    logic [15:0]     cosine_q, cosine_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic            eng_start_q, eng_start_d;
    logic            busy_q, busy_d;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [15:0]     pick_angle;
    logic [CW-1:0]   cand;
    logic            timed_out;

    // Cyclic search for the first requesting index starting at rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!pick_found && req[cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
        pick_angle = req_angle[{pick_idx, 4'b0000} +: 16];
    end

    assign timed_out = (timer_q == TW'(TIMEOUT - 1));

    // State register and all other flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            timer_q     <= '0;
            angle_q     <= '0;
            sine_q      <= '0;
            cosine_q    <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            timer_q     <= timer_d;
            angle_q     <= angle_d;
            sine_q      <= sine_d;
            cosine_q    <= cosine_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            eng_start_q <= eng_start_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath capture.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        angle_d  = angle_q;
        sine_d   = sine_q;
        cosine_d = cosine_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    gnt_d = pick_idx;
                    if (pick_angle > 16'd360) begin
                        err_d    = 1'b1;
                        sine_d   = '0;
                        cosine_d = '0;
                        state_d  = StResp;
                    end else begin
                        angle_d = pick_angle;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                state_d = StWaitClr;
            end
            StWaitClr: begin
                // A done still high here belongs to the previous operation.
                if (!eng_done) begin
                    state_d = StWaitDone;
                end else if (timed_out) begin
                    err_d    = 1'b1;
                    sine_d   = '0;
                    cosine_d = '0;
                    state_d  = StResp;
                end
            end
            StWaitDone: begin
                if (eng_done) begin
                    err_d    = 1'b0;
                    sine_d   = eng_sine;
                    cosine_d = eng_cosine;
                    state_d  = StResp;
                end else if (timed_out) begin
                    err_d    = 1'b1;
                    sine_d   = '0;
                    cosine_d = '0;
                    state_d  = StResp;
                end
            end
            StResp: begin
                rr_ptr_d = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q inside {StWaitClr, StWaitDone}) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Registered outputs follow the state being entered so they align with it.
    always_comb begin
        rsp_valid_d = '0;
        eng_start_d = (state_d == StIssue);
        busy_d      = (state_d != StIdle);
        if (state_d == StResp) begin
            rsp_valid_d[gnt_d] = 1'b1;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_sine   = sine_q;
    assign rsp_cosine = cosine_q;
    assign rsp_err    = err_q;
    assign busy       = busy_q;
    assign eng_start  = eng_start_q;
    assign eng_angle  = angle_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Self-checking bench for cordic_req_arbiter with a behavioural engine model whose
// latency, stale-done window and hang behaviour are controlled per scenario.
module tb_cordic_req_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic                 clk       = 1'b0;
    logic                 reset_n   = 1'b0;
    logic [NREQ-1:0]      req       = '0;
    logic [16*NREQ-1:0]   req_angle = '0;
    logic [NREQ-1:0]      rsp_valid;
    logic [15:0]          rsp_sine;
    logic [15:0]          rsp_cosine;
    logic                 rsp_err;
    logic                 busy;
    logic                 eng_start;
    logic [15:0]          eng_angle;
    logic [15:0]          eng_sine   = '0;
    logic [15:0]          eng_cosine = '0;
    logic                 eng_done   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    cordic_req_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_angle  (req_angle),
        .rsp_valid  (rsp_valid),
        .rsp_sine   (rsp_sine),
        .rsp_cosine (rsp_cosine),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_angle  (eng_angle),
        .eng_sine   (eng_sine),
        .eng_cosine (eng_cosine),
        .eng_done   (eng_done)
    );

    always #5 clk = ~clk;

    // Engine result is an arbitrary but angle-unique mapping; the arbiter does no math.
    function automatic logic [15:0] fs(input logic [15:0] a);
        return (a * 16'd37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] fc(input logic [15:0] a);
        return 16'h4000 - a * 16'd11;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Engine model: sticky done, optional delayed clear, optional hang, preset of stale result.
    bit          eng_hang    = 1'b0;
    bit          eng_preset  = 1'b0;
    int          eng_lat     = 0;
    int          eng_clr_dly = 0;
    int          eng_cnt     = 0;
    int          eng_clr     = 0;
    logic [15:0] eng_ang_l   = '0;

    always @(posedge clk) begin
        if (eng_preset) begin
            eng_done   <= 1'b1;
            eng_sine   <= 16'h7777;
            eng_cosine <= 16'h8888;
            eng_cnt    <= 0;
            eng_clr    <= 0;
        end else if (eng_start) begin
            eng_ang_l <= eng_angle;
            eng_clr   <= eng_clr_dly;
            eng_cnt   <= (eng_lat == 0) ? int'($urandom_range(35, 3)) : eng_lat;
            if (eng_clr_dly == 0) eng_done <= 1'b0;
        end else if (eng_clr > 0) begin
            eng_clr <= eng_clr - 1;
            if (eng_clr == 1) eng_done <= 1'b0;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && !eng_hang) begin
                eng_done   <= 1'b1;
                eng_sine   <= fs(eng_ang_l);
                eng_cosine <= fc(eng_ang_l);
            end
        end
    end

    // Monitor: logs every response and every engine start with its cycle number.
    int          cyc         = 0;
    int          n_rsp       = 0;
    int          n_starts    = 0;
    int          multi_hot   = 0;
    int          extra_start = 0;
    bit          start_pend  = 1'b0;
    int          rsp_idx_q[$];
    logic [15:0] rsp_sin_q[$];
    logic [15:0] rsp_cos_q[$];
    logic        rsp_err_q[$];
    int          rsp_cyc_q[$];
    logic [15:0] start_ang_q[$];
    int          start_cyc_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            start_pend <= 1'b0;
        end else if (eng_start) begin
            if (start_pend) extra_start <= extra_start + 1;
            start_pend <= 1'b1;
            n_starts   <= n_starts + 1;
            start_ang_q.push_back(eng_angle);
            start_cyc_q.push_back(cyc + 1);
        end
        if (|rsp_valid) begin
            if ($countones(rsp_valid) != 1) multi_hot <= multi_hot + 1;
            rsp_idx_q.push_back(onehot_idx(rsp_valid));
            rsp_sin_q.push_back(rsp_sine);
            rsp_cos_q.push_back(rsp_cosine);
            rsp_err_q.push_back(rsp_err);
            rsp_cyc_q.push_back(cyc + 1);
            n_rsp      <= n_rsp + 1;
            start_pend <= 1'b0;
        end
    end

    int model_ptr = 0;

    task automatic wait_rsp(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (n_rsp >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_start(input int s0);
        for (int i = 0; i < 10 && n_starts == s0; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive_req(input int k, input logic [15:0] ang);
        req_angle[16*k +: 16] = ang;
        req[k] = 1'b1;
    endtask

    task automatic preset_engine();
        @(posedge clk);
        #1 eng_preset = 1'b1;
        @(posedge clk);
        #1 eng_preset = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_err, busy, eng_start} !== 7'h0)
            $display("FAIL reset_ctrl: got %b want 0", {rsp_valid, rsp_err, busy, eng_start});
        n_checks++;
        if ({rsp_sine, rsp_cosine, eng_angle} !== 48'h0)
            $display("FAIL reset_data: got %h want 0", {rsp_sine, rsp_cosine, eng_angle});
        n_checks++;
        if (n_starts != 0 || n_rsp != 0)
            $display("FAIL reset_activity: starts %0d rsps %0d want 0", n_starts, n_rsp);
        n_fail += ({rsp_valid, rsp_err, busy, eng_start} !== 7'h0) ? 1 : 0;
        n_fail += ({rsp_sine, rsp_cosine, eng_angle} !== 48'h0) ? 1 : 0;
        n_fail += (n_starts != 0 || n_rsp != 0) ? 1 : 0;
        req = '0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single();
        int base, s0, rc;
        bit ok;
        eng_lat     = 20;
        eng_clr_dly = 0;
        base = n_rsp;
        s0   = n_starts;
        @(posedge clk);
        #1;
        rc = cyc;
        drive_req(0, 16'd30);
        wait_start(s0);
        req_angle[15:0] = 16'd999;  // must be ignored once latched
        wait_rsp(base + 1, 100, ok);
        req[0] = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout: got no response want one");
            return;
        end
        model_ptr = 1;
        n_checks++;
        if (rsp_idx_q[base] !== 0) begin
            n_fail++; $display("FAIL single_idx: got %0d want 0", rsp_idx_q[base]);
        end
        n_checks++;
        if (rsp_sin_q[base] !== fs(16'd30) || rsp_cos_q[base] !== fc(16'd30)) begin
            n_fail++;
            $display("FAIL single_data: got %h/%h want %h/%h", rsp_sin_q[base], rsp_cos_q[base],
                     fs(16'd30), fc(16'd30));
        end
        n_checks++;
        if (rsp_err_q[base] !== 1'b0) begin
            n_fail++; $display("FAIL single_err: got %b want 0", rsp_err_q[base]);
        end
        n_checks++;
        if (start_ang_q[s0] !== 16'd30) begin
            n_fail++; $display("FAIL single_eng_angle: got %0d want 30", start_ang_q[s0]);
        end
        n_checks++;
        if (start_cyc_q[s0] - rc != 2) begin
            n_fail++; $display("FAIL single_start_lat: got %0d want 2", start_cyc_q[s0] - rc);
        end
        n_checks++;
        if (rsp_cyc_q[base] - start_cyc_q[s0] != 22) begin
            n_fail++;
            $display("FAIL single_rsp_lat: got %0d want 22", rsp_cyc_q[base] - start_cyc_q[s0]);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (n_starts != s0 + 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: got starts %0d busy %b want %0d 0", n_starts - s0, busy, 1);
        end
    endtask

    task automatic test_rotation();
        logic [15:0] angs [NREQ];
        int base, e;
        bit ok;
        eng_lat = 0;
        angs[0] = 16'd0; angs[1] = 16'd90; angs[2] = 16'd180; angs[3] = 16'd270;
        base = n_rsp;
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) drive_req(k, angs[k]);
        wait_rsp(base + 5, 300, ok);
        req = '0;
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rot_timeout: got %0d rsps want 5", n_rsp - base);
            return;
        end
        for (int j = 0; j < 5; j++) begin
            e = model_ptr;
            model_ptr = (e + 1) % NREQ;
            n_checks++;
            if (rsp_idx_q[base+j] !== e) begin
                n_fail++; $display("FAIL rot_idx[%0d]: got %0d want %0d", j, rsp_idx_q[base+j], e);
            end
            n_checks++;
            if (rsp_sin_q[base+j] !== fs(angs[e]) || rsp_cos_q[base+j] !== fc(angs[e]) ||
                rsp_err_q[base+j] !== 1'b0) begin
                n_fail++;
                $display("FAIL rot_data[%0d]: got %h/%h/%b want %h/%h/0", j, rsp_sin_q[base+j],
                         rsp_cos_q[base+j], rsp_err_q[base+j], fs(angs[e]), fc(angs[e]));
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bad_angle();
        logic [15:0] tbl [5];
        logic [15:0] a;
        logic        bad;
        int base, s0, rc, k;
        bit ok;
        tbl[0] = 16'd400; tbl[1] = 16'd360; tbl[2] = 16'd361; tbl[3] = 16'hFFFF; tbl[4] = 16'd0;
        eng_lat = 0;
        for (int i = 0; i < 5; i++) begin
            a    = tbl[i];
            bad  = (a > 16'd360);
            k    = (i + 2) % NREQ;
            base = n_rsp;
            s0   = n_starts;
            @(posedge clk);
            #1;
            rc = cyc;
            drive_req(k, a);
            wait_rsp(base + 1, 100, ok);
            req[k] = 1'b0;
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL bad_timeout[%0d]: got no response want one", i);
                return;
            end
            model_ptr = (k + 1) % NREQ;
            n_checks++;
            if (rsp_idx_q[base] !== k || rsp_err_q[base] !== bad) begin
                n_fail++;
                $display("FAIL bad_idx_err[%0d]: got %0d/%b want %0d/%b", i, rsp_idx_q[base],
                         rsp_err_q[base], k, bad);
            end
            n_checks++;
            if (rsp_sin_q[base] !== (bad ? 16'h0 : fs(a)) ||
                rsp_cos_q[base] !== (bad ? 16'h0 : fc(a))) begin
                n_fail++;
                $display("FAIL bad_data[%0d]: got %h/%h for angle %0d", i, rsp_sin_q[base],
                         rsp_cos_q[base], a);
            end
            n_checks++;
            if (bad && (n_starts != s0 || rsp_cyc_q[base] - rc != 2)) begin
                n_fail++;
                $display("FAIL bad_reject[%0d]: got starts %0d lat %0d want 0 2", i,
                         n_starts - s0, rsp_cyc_q[base] - rc);
            end else if (!bad && (n_starts != s0 + 1 || start_ang_q[s0] !== a)) begin
                n_fail++;
                $display("FAIL bad_pass[%0d]: got starts %0d angle %0d want 1 %0d", i,
                         n_starts - s0, start_ang_q[s0], a);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int base, s0, k, want;
        bit ok;
        eng_lat = 10;
        for (int c = 0; c < 2; c++) begin
            k    = (c == 0) ? 1 : 3;
            want = (c == 0) ? TIMEOUT + 2 : TIMEOUT + 1;
            if (c == 0) begin
                eng_hang    = 1'b1;
                eng_clr_dly = 0;
            end else begin
                eng_hang = 1'b0;
                preset_engine();
                eng_clr_dly = 1000;  // done never drops: abort in the clear-wait state
            end
            base = n_rsp;
            s0   = n_starts;
            @(posedge clk);
            #1;
            drive_req(k, 16'd45);
            wait_rsp(base + 1, TIMEOUT + 40, ok);
            req[k] = 1'b0;
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL tmo_none[%0d]: got no response want one", c);
                eng_hang = 1'b0; eng_clr_dly = 0;
                return;
            end
            model_ptr = (k + 1) % NREQ;
            n_checks++;
            if (rsp_idx_q[base] !== k || rsp_err_q[base] !== 1'b1 ||
                rsp_sin_q[base] !== 16'h0 || rsp_cos_q[base] !== 16'h0) begin
                n_fail++;
                $display("FAIL tmo_rsp[%0d]: got idx %0d err %b data %h/%h want %0d 1 0/0", c,
                         rsp_idx_q[base], rsp_err_q[base], rsp_sin_q[base], rsp_cos_q[base], k);
            end
            n_checks++;
            if (rsp_cyc_q[base] - start_cyc_q[s0] != want) begin
                n_fail++;
                $display("FAIL tmo_lat[%0d]: got %0d want %0d", c,
                         rsp_cyc_q[base] - start_cyc_q[s0], want);
            end
            repeat (2) @(negedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL tmo_idle[%0d]: got busy %b want 0", c, busy);
            end
        end
        eng_hang    = 1'b0;
        eng_clr_dly = 0;
    endtask

    task automatic test_stale_done();
        logic [15:0] a;
        int base, k;
        bit ok;
        eng_lat = 10;
        for (int c = 0; c < 2; c++) begin
            k = (c == 0) ? 3 : 0;
            a = (c == 0) ? 16'd123 : 16'd270;
            eng_clr_dly = (c == 0) ? 3 : 5;
            preset_engine();
            base = n_rsp;
            @(posedge clk);
            #1;
            drive_req(k, a);
            wait_rsp(base + 1, 100, ok);
            req[k] = 1'b0;
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL stale_none[%0d]: got no response want one", c);
                eng_clr_dly = 0;
                return;
            end
            model_ptr = (k + 1) % NREQ;
            n_checks++;
            if (rsp_idx_q[base] !== k || rsp_err_q[base] !== 1'b0 ||
                rsp_sin_q[base] !== fs(a) || rsp_cos_q[base] !== fc(a)) begin
                n_fail++;
                $display("FAIL stale_rsp[%0d]: got idx %0d err %b data %h/%h want %0d 0 %h/%h",
                         c, rsp_idx_q[base], rsp_err_q[base], rsp_sin_q[base], rsp_cos_q[base],
                         k, fs(a), fc(a));
            end
            repeat (2) @(negedge clk);
        end
        eng_clr_dly = 0;
    endtask

    task automatic test_reset_mid();
        int base, s0;
        bit ok;
        eng_lat = 30;
        s0 = n_starts;
        @(posedge clk);
        #1;
        drive_req(0, 16'd60);
        wait_start(s0);
        repeat (6) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_err, busy, eng_start} !== 7'h0 ||
            {rsp_sine, rsp_cosine, eng_angle} !== 48'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %b %h want 0", {rsp_valid, rsp_err, busy, eng_start},
                     {rsp_sine, rsp_cosine, eng_angle});
        end
        req = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        model_ptr = 0;
        base = n_rsp;
        repeat (40) @(negedge clk);
        #1;
        n_checks++;
        if (n_rsp != base || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_dropped: got %0d rsps busy %b want 0 0", n_rsp - base, busy);
        end
        @(posedge clk);
        #1;
        drive_req(2, 16'd200);
        wait_rsp(base + 1, 100, ok);
        req[2] = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rstmid_next: got no response want one");
            return;
        end
        model_ptr = 3;
        n_checks++;
        if (rsp_idx_q[base] !== 2 || rsp_err_q[base] !== 1'b0 ||
            rsp_sin_q[base] !== fs(16'd200) || rsp_cos_q[base] !== fc(16'd200)) begin
            n_fail++;
            $display("FAIL rstmid_rsp: got idx %0d err %b data %h/%h want 2 0 %h/%h",
                     rsp_idx_q[base], rsp_err_q[base], rsp_sin_q[base], rsp_cos_q[base],
                     fs(16'd200), fc(16'd200));
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask;
        logic [15:0]     angs [NREQ];
        int order[$];
        int base, s0, good, e, got;
        bit ok;
        eng_lat = 0;
        for (int r = 0; r < 10; r++) begin
            mask = 4'($urandom_range(15, 1));
            order.delete();
            good = 0;
            for (int i = 0; i < NREQ; i++) begin
                e = (model_ptr + i) % NREQ;
                if (mask[e]) order.push_back(e);
            end
            base = n_rsp;
            s0   = n_starts;
            @(posedge clk);
            #1;
            for (int k = 0; k < NREQ; k++) begin
                angs[k] = 16'($urandom_range(420, 0));
                if (mask[k]) begin
                    drive_req(k, angs[k]);
                    if (angs[k] <= 16'd360) good++;
                end
            end
            for (int j = 0; j < order.size(); j++) begin
                wait_rsp(base + j + 1, 100, ok);
                n_checks++;
                if (!ok) begin
                    n_fail++; $display("FAIL rnd_timeout[%0d.%0d]: got no response want one", r, j);
                    req = '0;
                    return;
                end
                got = rsp_idx_q[base+j];
                if (got >= 0) req[got] = 1'b0;
                e = order[j];
                n_checks++;
                if (got !== e) begin
                    n_fail++; $display("FAIL rnd_idx[%0d.%0d]: got %0d want %0d", r, j, got, e);
                end
                n_checks++;
                if (rsp_err_q[base+j] !== (angs[e] > 16'd360) ||
                    rsp_sin_q[base+j] !== ((angs[e] > 16'd360) ? 16'h0 : fs(angs[e])) ||
                    rsp_cos_q[base+j] !== ((angs[e] > 16'd360) ? 16'h0 : fc(angs[e]))) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d.%0d]: got %b %h/%h for angle %0d", r, j,
                             rsp_err_q[base+j], rsp_sin_q[base+j], rsp_cos_q[base+j], angs[e]);
                end
                model_ptr = (e + 1) % NREQ;
            end
            repeat (2) @(negedge clk);
            #1;
            n_checks++;
            if (n_starts - s0 != good) begin
                n_fail++;
                $display("FAIL rnd_starts[%0d]: got %0d want %0d", r, n_starts - s0, good);
            end
        end
    endtask

    task automatic test_invariants();
        n_checks++;
        if (multi_hot != 0) begin
            n_fail++; $display("FAIL inv_onehot: got %0d multi-hot pulses want 0", multi_hot);
        end
        n_checks++;
        if (extra_start != 0) begin
            n_fail++; $display("FAIL inv_restart: got %0d extra starts want 0", extra_start);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_bad_angle();
        test_timeout();
        test_stale_done();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
